vga_field_overlay: RTL and testbench

Parametrised text-overlay character generator for the pipeline debug VGA screen. It sits between the pixel counter/fixed-text ROM and the glyph renderer. Per pixel, it replaces transparent cells of the fixed text (code 0x00) with digits of up to NUM_FIELDS live 32-bit debug values. The field layout is held in a runtime-writable descriptor table instead of hard-coded coordinates. Values are snapshotted once per frame, so each frame shows a coherent set of values, and the snapshot can be frozen.

---
 rtl/vga_overlay_pkg.sv | 41 ++++
 rtl/field_char_sel.sv | 38 +++
 rtl/vga_field_overlay.sv | 198 +++++++++++++++++++
 tb/tb_vga_field_overlay.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_overlay_pkg.sv
// Shared types and constants for the VGA debug-field overlay.
// Holds the radix encoding, descriptor layout and per-radix length limits.
package vga_overlay_pkg;

    typedef enum logic [1:0] {
        RADIX_HEX = 2'd0,
        RADIX_BIN = 2'd1,
        RADIX_ASC = 2'd2,
        RADIX_RSV = 2'd3
    } radix_e;

    typedef struct packed {
        logic       en;
        logic [6:0] col;
        logic [4:0] row;
        radix_e     radix;
        logic [5:0] len;
    } field_desc_t;

    localparam int unsigned MAX_LEN_HEX = 8;
    localparam int unsigned MAX_LEN_BIN = 32;
    localparam int unsigned MAX_LEN_ASC = 4;
    localparam int unsigned NUM_COLS    = 80;

    // Stored length is always 1..max for the radix, so stage 2 never indexes past the value.
    function automatic logic [5:0] clamp_len(input radix_e radix, input logic [5:0] len);
        logic [5:0] max_len;
        case (radix)
            RADIX_BIN: max_len = 6'(MAX_LEN_BIN);
            RADIX_ASC: max_len = 6'(MAX_LEN_ASC);
            default:   max_len = 6'(MAX_LEN_HEX);
        endcase
        if (len == 6'd0) begin
            return 6'd1;
        end else if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/field_char_sel.sv
// Combinational digit extractor: picks position k (counted from the LSB end)
// of a value and renders it as a hex digit, binary digit or raw byte.
module field_char_sel
    import vga_overlay_pkg::*;
#(
    parameter int unsigned VALUE_W = 32
) (
    input  logic [VALUE_W-1:0] value,
    input  radix_e             radix,
    input  logic [4:0]         k,
    output logic [7:0]         char_code
);

    logic [3:0] nibble;
    logic [7:0] byte_val;
    logic       bit_val;

    assign nibble   = value[{k[2:0], 2'b00} +: 4];
    assign byte_val = value[{k[1:0], 3'b000} +: 8];
    assign bit_val  = value[k];

    always_comb begin
        char_code = 8'h00;
        case (radix)
            RADIX_BIN: char_code = bit_val ? 8'h31 : 8'h30;
            RADIX_ASC: char_code = byte_val;
            default: begin
                // Reserved radix renders as hex; 0x37 + 10 = 'A'.
                if (nibble < 4'd10) begin
                    char_code = 8'h30 + {4'h0, nibble};
                end else begin
                    char_code = 8'h37 + {4'h0, nibble};
                end
            end
        endcase
    end

endmodule

// File: rtl/vga_field_overlay.sv
// Two-stage text overlay: stage 1 decodes the cell against the descriptor table,
// stage 2 renders the digit from the per-frame shadow and muxes with fixed text.
module vga_field_overlay
    import vga_overlay_pkg::*;
#(
    parameter int unsigned NUM_FIELDS = 64,
    parameter int unsigned VALUE_W    = 32,
    parameter int unsigned CHAR_W     = 8,
    parameter int unsigned CHAR_H     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [9:0]                     x,
    input  logic [9:0]                     y,
    input  logic                           video_on,
    input  logic [7:0]                     fixed_ascii,
    input  logic [NUM_FIELDS*VALUE_W-1:0]  values,
    input  logic                           freeze,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_FIELDS)-1:0]  cfg_idx,
    input  logic [6:0]                     cfg_col,
    input  logic [4:0]                     cfg_row,
    input  logic [1:0]                     cfg_radix,
    input  logic [5:0]                     cfg_len,
    input  logic                           cfg_en,
    output logic [7:0]                     ascii_char,
    output logic [9:0]                     x_out,
    output logic [9:0]                     y_out,
    output logic                           video_on_out,
    output logic                           field_hit,
    output logic                           frame_tick
);

    localparam int unsigned IDX_W     = $clog2(NUM_FIELDS);
    localparam int unsigned COL_SHIFT = $clog2(CHAR_W);
    localparam int unsigned ROW_SHIFT = $clog2(CHAR_H);

    field_desc_t        desc_q   [NUM_FIELDS];
    logic [VALUE_W-1:0] shadow_q [NUM_FIELDS];
    field_desc_t        cfg_desc;
    logic               snap;

    assign snap = (x == 10'd0) && (y == 10'd0) && !freeze;

    always_comb begin
        cfg_desc.en    = cfg_en;
        cfg_desc.col   = cfg_col;
        cfg_desc.row   = cfg_row;
        cfg_desc.radix = radix_e'(cfg_radix);
        cfg_desc.len   = clamp_len(radix_e'(cfg_radix), cfg_len);
    end

    // Descriptor table and shadow are independent flop arrays so a write and a
    // snapshot in the same cycle both land.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                desc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                    desc_q[i] <= cfg_desc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (snap) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                shadow_q[i] <= values[i*VALUE_W +: VALUE_W];
            end
        end
    end

    // ---------------- Stage 1: cell decode ----------------
    logic [9:0]            cell_col;
    logic [9:0]            cell_row;
    logic [NUM_FIELDS-1:0] hit_vec;
    logic                  any_hit;
    logic [IDX_W-1:0]      hit_idx;
    logic [4:0]            digit;
    logic [4:0]            kpos;

    assign cell_col = x >> COL_SHIFT;
    assign cell_row = y >> ROW_SHIFT;

    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_match
        logic [9:0] span_start;
        logic [9:0] span_end;
        assign span_start  = {3'b000, desc_q[gi].col};
        assign span_end    = span_start + {4'b0000, desc_q[gi].len};
        // The column-80 bound clips spans instead of letting them wrap.
        assign hit_vec[gi] = desc_q[gi].en
                          && (cell_row == {5'b00000, desc_q[gi].row})
                          && (cell_col >= span_start)
                          && (cell_col < span_end)
                          && (cell_col < 10'(NUM_COLS));
    end

    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                any_hit = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Spans are at most 32 cells, so 5-bit wrap-around arithmetic is exact.
    assign digit = cell_col[4:0] - desc_q[hit_idx].col[4:0];
    assign kpos  = desc_q[hit_idx].len[4:0] - 5'd1 - digit;

    logic [9:0]       s1_x;
    logic [9:0]       s1_y;
    logic             s1_vid;
    logic [7:0]       s1_fixed;
    logic             s1_hit;
    logic [IDX_W-1:0] s1_idx;
    radix_e           s1_radix;
    logic [4:0]       s1_k;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_x     <= '0;
            s1_y     <= '0;
            s1_vid   <= 1'b0;
            s1_fixed <= '0;
            s1_hit   <= 1'b0;
            s1_idx   <= '0;
            s1_radix <= RADIX_HEX;
            s1_k     <= '0;
        end else begin
            s1_x     <= x;
            s1_y     <= y;
            s1_vid   <= video_on;
            s1_fixed <= fixed_ascii;
            s1_hit   <= any_hit;
            s1_idx   <= hit_idx;
            s1_radix <= desc_q[hit_idx].radix;
            s1_k     <= kpos;
        end
    end

    // ---------------- Stage 2: character select and mux ----------------
    logic [7:0] field_char;
    logic [7:0] char_d;
    logic       hit_d;

    field_char_sel #(
        .VALUE_W (VALUE_W)
    ) u_char_sel (
        .value     (shadow_q[s1_idx]),
        .radix     (s1_radix),
        .k         (s1_k),
        .char_code (field_char)
    );

    always_comb begin
        char_d = 8'h00;
        hit_d  = 1'b0;
        if (s1_vid) begin
            if (s1_hit && (s1_fixed == 8'h00)) begin
                char_d = field_char;
                hit_d  = 1'b1;
            end else begin
                char_d = s1_fixed;
            end
        end
    end

    // frame_tick is registered so it is high while the freshly loaded shadow is live.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ascii_char   <= '0;
            x_out        <= '0;
            y_out        <= '0;
            video_on_out <= 1'b0;
            field_hit    <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            ascii_char   <= char_d;
            x_out        <= s1_x;
            y_out        <= s1_y;
            video_on_out <= s1_vid;
            field_hit    <= hit_d;
            frame_tick   <= snap;
        end
    end

endmodule

// File: tb/tb_vga_field_overlay.sv
// Randomized bench for vga_field_overlay against a cell-level behavioural model
// (descriptor list, per-frame shadow, two-deep expected-output queue).
module tb_vga_field_overlay;

    localparam int NF = 8;
    localparam int VW = 32;
    localparam int IW = $clog2(NF);

    logic             clk = 1'b0;
    logic             reset;
    logic [9:0]       x, y;
    logic             video_on;
    logic [7:0]       fixed_ascii;
    logic [NF*VW-1:0] values;
    logic             freeze;
    logic             cfg_we;
    logic [IW-1:0]    cfg_idx;
    logic [6:0]       cfg_col;
    logic [4:0]       cfg_row;
    logic [1:0]       cfg_radix;
    logic [5:0]       cfg_len;
    logic             cfg_en;
    logic [7:0]       ascii_char;
    logic [9:0]       x_out, y_out;
    logic             video_on_out, field_hit, frame_tick;

    vga_field_overlay #(
        .NUM_FIELDS (NF),
        .VALUE_W    (VW),
        .CHAR_W     (8),
        .CHAR_H     (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .video_on     (video_on),
        .fixed_ascii  (fixed_ascii),
        .values       (values),
        .freeze       (freeze),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_col      (cfg_col),
        .cfg_row      (cfg_row),
        .cfg_radix    (cfg_radix),
        .cfg_len      (cfg_len),
        .cfg_en       (cfg_en),
        .ascii_char   (ascii_char),
        .x_out        (x_out),
        .y_out        (y_out),
        .video_on_out (video_on_out),
        .field_hit    (field_hit),
        .frame_tick   (frame_tick)
    );

    always #20 clk = ~clk;

    typedef struct {
        int ch;
        int xo;
        int yo;
        int vo;
        int hit;
    } exp_t;

    int          m_en [NF];
    int          m_col[NF];
    int          m_row[NF];
    int          m_rad[NF];
    int          m_len[NF];
    logic [31:0] m_shadow[NF];
    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        exp_t z;
        z = '{ch: 0, xo: 0, yo: 0, vo: 0, hit: 0};
        for (int i = 0; i < NF; i++) begin
            m_en[i] = 0;
            m_shadow[i] = 32'h0;
        end
        exp_q.delete();
        exp_q.push_back(z);
    endtask

    function automatic exp_t expect_pixel();
        exp_t        e;
        int          col, row, best, k, n;
        logic [31:0] v;
        e = '{ch: 0, xo: int'(x), yo: int'(y), vo: int'(video_on), hit: 0};
        if (!video_on) return e;
        col  = int'(x) / 8;
        row  = int'(y) / 16;
        best = -1;
        for (int i = 0; i < NF; i++) begin
            if (best < 0 && m_en[i] != 0 && m_row[i] == row && col >= m_col[i]
                && col < m_col[i] + m_len[i] && col < 80) best = i;
        end
        if (fixed_ascii != 8'h00 || best < 0) begin
            e.ch = int'(fixed_ascii);
            return e;
        end
        e.hit = 1;
        k = m_len[best] - 1 - (col - m_col[best]);
        v = m_shadow[best];
        case (m_rad[best])
            1:       e.ch = 48 + int'((v >> k) & 32'h1);
            2:       e.ch = int'((v >> (8 * k)) & 32'hFF);
            default: begin
                n    = int'((v >> (4 * k)) & 32'hF);
                e.ch = (n < 10) ? 48 + n : 65 + n - 10;
            end
        endcase
        return e;
    endfunction

    // One clock: update model as of this edge, then compare outputs #1 later.
    task automatic tick();
        exp_t p;
        int   snap, mx;
        @(posedge clk);
        snap = (x == 0 && y == 0 && !freeze) ? 1 : 0;
        if (snap != 0) begin
            for (int i = 0; i < NF; i++) m_shadow[i] = values[i*VW +: VW];
        end
        exp_q.push_back(expect_pixel());
        if (cfg_we) begin
            mx = (cfg_radix == 2'd1) ? 32 : ((cfg_radix == 2'd2) ? 4 : 8);
            m_en [cfg_idx] = int'(cfg_en);
            m_col[cfg_idx] = int'(cfg_col);
            m_row[cfg_idx] = int'(cfg_row);
            m_rad[cfg_idx] = int'(cfg_radix);
            m_len[cfg_idx] = (cfg_len == 0) ? 1 : ((int'(cfg_len) > mx) ? mx : int'(cfg_len));
        end
        #1;
        p = exp_q.pop_front();
        check_eq("ascii_char", 32'(ascii_char), 32'(p.ch));
        check_eq("x_out", 32'(x_out), 32'(p.xo));
        check_eq("y_out", 32'(y_out), 32'(p.yo));
        check_eq("video_on_out", 32'(video_on_out), 32'(p.vo));
        check_eq("field_hit", 32'(field_hit), 32'(p.hit));
        check_eq("frame_tick", 32'(frame_tick), 32'(snap));
        cfg_we = 1'b0;
    endtask

    task automatic pix(input int px, input int py, input int vo, input int fa);
        x = 10'(px);
        y = 10'(py);
        video_on = vo[0];
        fixed_ascii = 8'(fa);
        tick();
    endtask

    task automatic write_desc(input int idx, input int col, input int row, input int rad,
                              input int len, input int en);
        cfg_we    = 1'b1;
        cfg_idx   = IW'(idx);
        cfg_col   = 7'(col);
        cfg_row   = 5'(row);
        cfg_radix = 2'(rad);
        cfg_len   = 6'(len);
        cfg_en    = en[0];
    endtask

    task automatic scan(input int cell_row, input int c0, input int c1, input int fa);
        for (int c = c0; c <= c1; c++) begin
            pix(c * 8 + int'($urandom_range(0, 7)), cell_row * 16 + int'($urandom_range(0, 15)),
                1, fa);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ascii"}, 32'(ascii_char), 32'h0);
        check_eq({tag, "_x"}, 32'(x_out), 32'h0);
        check_eq({tag, "_y"}, 32'(y_out), 32'h0);
        check_eq({tag, "_vid"}, 32'(video_on_out), 32'h0);
        check_eq({tag, "_hit"}, 32'(field_hit), 32'h0);
        check_eq({tag, "_tick"}, 32'(frame_tick), 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        x = '0; y = '0; video_on = 1'b0; fixed_ascii = '0; values = '0; freeze = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_col = '0; cfg_row = '0; cfg_radix = '0;
        cfg_len = '0; cfg_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("por");
        reset = 1'b1;
        model_reset();

        // Mid-frame reset, then zero-valued field before the first snapshot.
        values[0*VW +: VW] = 32'hCAFE_F00D;
        write_desc(0, 12, 1, 0, 8, 1);
        pix(0, 0, 1, 0);
        scan(1, 10, 22, 0);
        x = 10'd400; y = 10'd200; video_on = 1'b1; fixed_ascii = 8'h41;
        #3;
        reset = 1'b0;
        #2;
        check_outputs_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        values[0*VW +: VW] = 32'h1234_ABCD;
        write_desc(0, 12, 1, 0, 8, 1);
        pix(500, 300, 1, 0);
        scan(1, 10, 21, 0);
        pix(0, 0, 1, 0);
        scan(1, 10, 21, 0);

        // Binary with clamped length; span beyond 32 cells must not hit.
        values[3*VW +: VW] = 32'h0000_0055;
        write_desc(3, 0, 3, 1, 40, 1);
        pix(0, 0, 1, 0);
        scan(3, 0, 36, 0);
        write_desc(3, 0, 3, 1, 1, 1);
        pix(8, 48, 1, 0);
        scan(3, 0, 2, 0);

        // Overlapping entries and fixed-text precedence.
        values[2*VW +: VW] = 32'h89AB_CDEF;
        values[5*VW +: VW] = 32'h4142_4344;
        write_desc(2, 30, 5, 0, 8, 1);
        pix(0, 0, 1, 0);
        write_desc(5, 28, 5, 2, 4, 1);
        pix(0, 0, 1, 0);
        scan(5, 26, 40, 0);
        scan(5, 26, 40, 8'h41);

        // Freeze holds the old snapshot across frames.
        freeze = 1'b1;
        values[0*VW +: VW] = 32'hFFFF_FFFF;
        for (int f = 0; f < 2; f++) begin
            pix(0, 0, 1, 0);
            scan(1, 12, 19, 0);
        end
        freeze = 1'b0;
        scan(1, 12, 19, 0);
        pix(0, 0, 1, 0);
        scan(1, 12, 19, 0);

        // Clipping at column 79, no wrap onto the next row.
        write_desc(1, 76, 2, 0, 8, 1);
        pix(0, 0, 1, 0);
        scan(2, 74, 90, 0);
        scan(3, 0, 3, 0);

        // Rewrite a descriptor mid-line.
        for (int c = 10; c <= 30; c++) begin
            if (c == 15) write_desc(0, 20, 1, 0, 8, 1);
            pix(c * 8 + int'($urandom_range(0, 7)), 16 + int'($urandom_range(0, 15)), 1, 0);
        end

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                write_desc(int'($urandom_range(0, NF - 1)), int'($urandom_range(0, 79)),
                           int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 63)), int'($urandom_range(0, 4) != 0));
            end
            if ($urandom_range(0, 19) == 0) begin
                values[$urandom_range(0, NF - 1)*VW +: VW] = $urandom;
            end
            if ($urandom_range(0, 49) == 0) freeze = ~freeze;
            if ($urandom_range(0, 29) == 0) begin
                pix(0, 0, int'($urandom_range(0, 9) != 0), 0);
            end else begin
                pix(int'($urandom_range(0, 760)),
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 524))
                                                : int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(32, 126)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
